grp_mem_arbiter: RTL

//  Shares the single group-RAM write port (orbit word/address/wren) among N_REQ MCM packers.

---
 rtl/grp_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/grp_mem_arbiter.sv
// rtl/grp_mem_arbiter.sv - round-robin arbiter sharing the group-RAM write port among MCM packers
// One grant per LCB free window (busy falling edge), with watchdog release and conflict flag.
module grp_mem_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 12,
  parameter int AW    = 10,
  parameter int TMO   = 4095
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    iReq,
  input  logic [N_REQ*DW-1:0] iData,
  input  logic [N_REQ*AW-1:0] iAddr,
  input  logic [N_REQ-1:0]    iWren,
  input  logic                iLcbBusy,
  output logic [N_REQ-1:0]    oGnt,
  output logic [DW-1:0]       oData,
  output logic [AW-1:0]       oAddr,
  output logic                oWren,
  output logic                oBusy,
  output logic                oTimeout,
  output logic                oConflict
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic [2:0]      busy_sync;
  logic            mem_free;
  logic [11:0]     wd;

  logic            busy_fall;
  logic            busy_rise;
  logic [PW-1:0]   pick;
  logic            pick_ok;
  logic [PW-1:0]   idx;

  assign busy_fall = busy_sync[2] & ~busy_sync[1];
  assign busy_rise = ~busy_sync[2] & busy_sync[1];

  // Round-robin scan starting just after the last released channel.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!pick_ok && iReq[idx]) begin
        pick_ok = 1'b1;
        pick    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= PW'(N_REQ - 1);
      sel       <= '0;
      busy_sync <= '0;
      mem_free  <= 1'b0;
      wd        <= '0;
      oGnt      <= '0;
      oData     <= '0;
      oAddr     <= '0;
      oWren     <= 1'b0;
      oBusy     <= 1'b0;
      oTimeout  <= 1'b0;
      oConflict <= 1'b0;
    end else begin
      busy_sync <= {busy_sync[1:0], iLcbBusy};
      oTimeout  <= 1'b0;

      if (busy_fall) begin
        mem_free <= 1'b1;
      end else if (busy_rise) begin
        mem_free <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (mem_free && pick_ok) begin
            sel   <= pick;
            oGnt  <= N_REQ'(1) << pick;
            oBusy <= 1'b1;
            wd    <= '0;
            state <= OWN;
            // The window is consumed by this grant; a fall arriving now opens the next one.
            if (!busy_fall) begin
              mem_free <= 1'b0;
            end
          end
        end
        OWN: begin
          if (busy_rise) begin
            oConflict <= 1'b1;
          end
          if (!iReq[sel] || wd == 12'(TMO)) begin
            oGnt     <= '0;
            oWren    <= 1'b0;
            oBusy    <= 1'b0;
            ptr      <= sel;
            state    <= IDLE;
            oTimeout <= iReq[sel];
          end else begin
            oData <= iData[sel*DW +: DW];
            oAddr <= iAddr[sel*AW +: AW];
            oWren <= iWren[sel];
            wd    <= wd + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
